// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: loads IR in two byte steps and bumps the PC once per byte.
// Latency: Done is high 3 cycles after the Start edge (counting that edge's cycle); each stall cycle adds one.
// Backpressure: Stall freezes the current load state with MemRead held; Abort drops back to IDLE without completing.
module fetch_sequencer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Abort,
  output logic        MemRead,
  output logic        IR_E,
  output logic [2:0]  IR_FunSel,
  output logic        PC_E,
  output logic [2:0]  PC_FunSel,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] FetchCount
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] FS_NONE   = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOW    = 3'b101;
  localparam logic [2:0] FS_HIGH   = 3'b110;
  // Byte order decides which IR half is written by the first load state.
  localparam logic [2:0] FS_FIRST  = LSB_FIRST ? FS_LOW  : FS_HIGH;
  localparam logic [2:0] FS_SECOND = LSB_FIRST ? FS_HIGH : FS_LOW;

  state_t      state;
  logic        mem_read_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] count_q;
  logic        load_go;

  // State machine with registered MemRead/Busy/Done and the completed-fetch counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state      <= ST_LOAD_A;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          // Abort wins over Stall; a stalled load simply holds everything.
          if (Abort) begin
            state      <= ST_IDLE;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (!Stall) begin
            state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (Abort) begin
            state      <= ST_IDLE;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (!Stall) begin
            state      <= ST_DONE;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          // The counter wraps naturally; a held Start chains straight into the next fetch.
          count_q <= count_q + 16'd1;
          if (Start) begin
            state      <= ST_LOAD_A;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          mem_read_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Register enables and FunSels follow the live Stall/Abort so a frozen cycle never writes.
  always_comb begin
    load_go   = ((state == ST_LOAD_A) || (state == ST_LOAD_B)) && !Stall && !Abort;
    IR_E      = load_go;
    PC_E      = load_go;
    PC_FunSel = load_go ? FS_INC : FS_NONE;
    IR_FunSel = FS_NONE;
    if (load_go) begin
      IR_FunSel = (state == ST_LOAD_A) ? FS_FIRST : FS_SECOND;
    end
  end

  assign MemRead    = mem_read_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: one instance per byte order, table-driven cycle vectors
// plus hand sequences for counter wrap and reset in the middle of a fetch.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with low byte first
  logic        rst_n, start, stall, abort;
  logic        mem_read, ir_e, pc_e, busy, done;
  logic [2:0]  ir_fs, pc_fs;
  logic [15:0] fcount;

  // Instance with high byte first
  logic        rst2_n, start2, stall2, abort2;
  logic        mem_read2, ir_e2, pc_e2, busy2, done2;
  logic [2:0]  ir_fs2, pc_fs2;
  logic [15:0] fcount2;

  fetch_sequencer #(.LSB_FIRST(1'b1)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .Stall(stall), .Abort(abort),
    .MemRead(mem_read), .IR_E(ir_e), .IR_FunSel(ir_fs), .PC_E(pc_e),
    .PC_FunSel(pc_fs), .Busy(busy), .Done(done), .FetchCount(fcount)
  );

  fetch_sequencer #(.LSB_FIRST(1'b0)) dut2 (
    .Clock(clk), .Reset(rst2_n), .Start(start2), .Stall(stall2), .Abort(abort2),
    .MemRead(mem_read2), .IR_E(ir_e2), .IR_FunSel(ir_fs2), .PC_E(pc_e2),
    .PC_FunSel(pc_fs2), .Busy(busy2), .Done(done2), .FetchCount(fcount2)
  );

  logic [26:0] o1, o2;
  assign o1 = {mem_read,  ir_e,  ir_fs,  pc_e,  pc_fs,  busy,  done,  fcount};
  assign o2 = {mem_read2, ir_e2, ir_fs2, pc_e2, pc_fs2, busy2, done2, fcount2};

  // Control field order: MemRead, IR_E, IR_FunSel, PC_E, PC_FunSel, Busy, Done
  localparam logic [10:0] O_IDLE = 11'b0_0_000_0_000_0_0;
  localparam logic [10:0] O_LA   = 11'b1_1_101_1_001_1_0;
  localparam logic [10:0] O_LB   = 11'b1_1_110_1_001_1_0;
  localparam logic [10:0] O_HOLD = 11'b1_0_000_0_000_1_0;
  localparam logic [10:0] O_DONE = 11'b0_0_000_0_000_0_1;
  localparam logic [10:0] O_LA2  = 11'b1_1_110_1_001_1_0;
  localparam logic [10:0] O_LB2  = 11'b1_1_101_1_001_1_0;

  typedef struct {
    logic        s;
    logic        st;
    logic        ab;
    logic [10:0] eo;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs [0:36];

  int n_checks = 0;
  int n_fail   = 0;
  int pc_inc   = 0;
  int ir_inc   = 0;

  function automatic vec_t mk(input logic s, input logic st, input logic ab,
                              input logic [10:0] eo, input logic [15:0] ec);
    vec_t v;
    v.s = s; v.st = st; v.ab = ab; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
               name, act[26:16], act[15:0], exp[26:16], exp[15:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, sample 1ns later, tally PC/IR enables seen by the next rising edge.
  task automatic step1(input logic s, input logic st, input logic ab,
                       input logic [10:0] eo, input logic [15:0] ec, input string name);
    @(negedge clk);
    start = s; stall = st; abort = ab;
    #1;
    if (ir_e && ir_fs != 3'b000) ir_inc++;
    if (pc_e && pc_fs == 3'b001) pc_inc++;
    check(name, o1, {eo, ec});
  endtask

  task automatic step2(input logic s, input logic [10:0] eo, input logic [15:0] ec,
                       input string name);
    @(negedge clk);
    start2 = s;
    #1;
    check(name, o2, {eo, ec});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    rst2_n = 1'b0; start2 = 1'b0; stall2 = 1'b0; abort2 = 1'b0;

    // Single fetch
    vecs[0]  = mk(0,0,0, O_IDLE, 16'd0);
    vecs[1]  = mk(1,0,0, O_IDLE, 16'd0);
    vecs[2]  = mk(0,0,0, O_LA,   16'd0);
    vecs[3]  = mk(0,0,0, O_LB,   16'd0);
    vecs[4]  = mk(0,0,0, O_DONE, 16'd0);
    vecs[5]  = mk(0,0,0, O_IDLE, 16'd1);
    // Two stall cycles in LOAD_B: Done lands 5 cycles after Start
    vecs[6]  = mk(1,0,0, O_IDLE, 16'd1);
    vecs[7]  = mk(0,0,0, O_LA,   16'd1);
    vecs[8]  = mk(0,1,0, O_HOLD, 16'd1);
    vecs[9]  = mk(0,1,0, O_HOLD, 16'd1);
    vecs[10] = mk(0,0,0, O_LB,   16'd1);
    vecs[11] = mk(0,0,0, O_DONE, 16'd1);
    // Abort together with Stall in LOAD_A, then Abort/Stall in IDLE are ignored
    vecs[12] = mk(1,0,0, O_IDLE, 16'd2);
    vecs[13] = mk(0,1,1, O_HOLD, 16'd2);
    vecs[14] = mk(0,0,0, O_IDLE, 16'd2);
    vecs[15] = mk(0,1,1, O_IDLE, 16'd2);
    // Start ignored in LOAD_A, abort in LOAD_B
    vecs[16] = mk(1,0,0, O_IDLE, 16'd2);
    vecs[17] = mk(1,0,0, O_LA,   16'd2);
    vecs[18] = mk(0,0,1, O_HOLD, 16'd2);
    vecs[19] = mk(0,0,0, O_IDLE, 16'd2);
    // Start held: Done every 3 cycles, five back-to-back fetches
    vecs[20] = mk(1,0,0, O_IDLE, 16'd2);
    vecs[21] = mk(1,0,0, O_LA,   16'd2);
    vecs[22] = mk(1,0,0, O_LB,   16'd2);
    vecs[23] = mk(1,0,0, O_DONE, 16'd2);
    vecs[24] = mk(1,0,0, O_LA,   16'd3);
    vecs[25] = mk(1,0,0, O_LB,   16'd3);
    vecs[26] = mk(1,0,0, O_DONE, 16'd3);
    vecs[27] = mk(1,0,0, O_LA,   16'd4);
    vecs[28] = mk(1,0,0, O_LB,   16'd4);
    vecs[29] = mk(1,0,0, O_DONE, 16'd4);
    vecs[30] = mk(1,0,0, O_LA,   16'd5);
    vecs[31] = mk(1,0,0, O_LB,   16'd5);
    vecs[32] = mk(1,0,0, O_DONE, 16'd5);
    vecs[33] = mk(0,0,0, O_LA,   16'd6);
    vecs[34] = mk(0,0,0, O_LB,   16'd6);
    vecs[35] = mk(0,0,0, O_DONE, 16'd6);
    vecs[36] = mk(0,0,0, O_IDLE, 16'd7);

    // Reset acts before any clock edge
    #3;
    check("reset_lsb", o1, 27'd0);
    check("reset_msb", o2, 27'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;

    for (int i = 0; i <= 36; i++) begin
      step1(vecs[i].s, vecs[i].st, vecs[i].ab, vecs[i].eo, vecs[i].ec,
            $sformatf("vec%0d", i));
    end

    // 2+2 (clean/stalled) + 0 (abort in A) + 1 (abort in B) + 5*2 (back-to-back)
    check_int("pc_increments", pc_inc, 15);
    check_int("ir_vs_pc_enables", ir_inc, pc_inc);

    // Counter wrap: preload 0xFFFF, one more fetch wraps to 0 and still pulses Done
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    step1(0,0,0, O_IDLE, 16'hFFFF, "wrap_preload");
    step1(1,0,0, O_IDLE, 16'hFFFF, "wrap_start");
    step1(0,0,0, O_LA,   16'hFFFF, "wrap_load_a");
    step1(0,0,0, O_LB,   16'hFFFF, "wrap_load_b");
    step1(0,0,0, O_DONE, 16'hFFFF, "wrap_done");
    step1(0,0,0, O_IDLE, 16'h0000, "wrap_zero");

    // High-byte-first instance: one full fetch, then reset in LOAD_B of the second
    step2(1, O_IDLE, 16'd0, "msb_start");
    step2(0, O_LA2,  16'd0, "msb_load_a");
    step2(0, O_LB2,  16'd0, "msb_load_b");
    step2(0, O_DONE, 16'd0, "msb_done");
    step2(0, O_IDLE, 16'd1, "msb_idle");
    step2(1, O_IDLE, 16'd1, "msb_start2");
    step2(0, O_LA2,  16'd1, "msb_load_a2");
    step2(0, O_LB2,  16'd1, "msb_load_b2");
    #2;
    rst2_n = 1'b0;
    #1;
    check("msb_reset_async", o2, 27'd0);
    step2(0, O_IDLE, 16'd0, "msb_in_reset");
    @(negedge clk);
    rst2_n = 1'b1;
    start2 = 1'b1;
    step2(0, O_LA2,  16'd0, "msb_first_start");
    step2(0, O_LB2,  16'd0, "msb_after_reset_b");
    step2(0, O_DONE, 16'd0, "msb_after_reset_done");
    step2(0, O_IDLE, 16'd1, "msb_after_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
